csa_resolve: RTL and testbench

- Converts a carry-save pair (in_sum, in_carry), as produced by the 4:2 compressor stage of the vfpu multiplier tree, into a single binary value.
- Uses a multi-cycle chunked carry-propagate adder: CHUNK bits per cycle, with the chunk carry held in a flop.
- Trades latency for a short adder path.
- Uses a valid/ready handshake on both the input and the output side.

---
 rtl/csa_resolve_if.sv | 30 +++
 rtl/csa_resolve.sv | 129 ++++++++++++
 tb/tb_csa_resolve.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_resolve_if.sv
`default_nettype none
// ============================================================================
// Module  : csa_resolve_if
// Purpose : Operand/result handshake bundle for the carry-save resolver.
// Revision: 1.0  initial release
// ============================================================================
interface csa_resolve_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_sum;
    logic [WIDTH:0]   in_carry;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, in_sum, in_carry, in_cin, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_cin, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface
`default_nettype wire

// File: rtl/csa_resolve.sv
`default_nettype none
// ============================================================================
// Module  : csa_resolve
// Purpose : Multi-cycle chunked carry-propagate adder collapsing a carry-save
//           pair (plus carry-in) into one full-precision binary result.
// Revision: 1.0  initial release
// ============================================================================
module csa_resolve #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire         clk,
    input  wire         rst_n,
    csa_resolve_if.slave bus
);

    localparam int NCH  = (WIDTH + 1 + CHUNK - 1) / CHUNK;
    localparam int c_PW = NCH * CHUNK;
    localparam int c_CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_PW-1:0]     r_sum;
    logic [c_PW-1:0]     r_carry;
    logic [c_PW-1:0]     r_res;
    logic                r_cc;
    logic [c_CW-1:0]     r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [WIDTH+1:0]    r_out_result;

    logic [c_PW-1:0]     w_sum_ext;
    logic [c_PW-1:0]     w_carry_ext;
    logic [c_PW-1:0]     w_res_next;
    logic [CHUNK:0]      w_csum;
    logic [c_PW:0]       w_final;
    logic                w_last;
    logic                w_unused;

    always_comb begin
        w_sum_ext              = '0;
        w_sum_ext[WIDTH:0]     = bus.in_sum;
        w_carry_ext            = '0;
        w_carry_ext[WIDTH:0]   = bus.in_carry;
        w_csum = {1'b0, r_sum[r_cnt*CHUNK +: CHUNK]}
               + {1'b0, r_carry[r_cnt*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, r_cc};
        w_res_next                       = r_res;
        w_res_next[r_cnt*CHUNK +: CHUNK] = w_csum[CHUNK-1:0];
        // Final carry sits above the padded result; bit WIDTH+1 lands in the
        // padding when CHUNK does not divide WIDTH+1, else in the carry.
        w_final = {w_csum[CHUNK], w_res_next};
    end

    assign w_last   = (r_cnt == c_CW'(NCH - 1));
    assign w_unused = &{1'b0, w_final};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sum        <= '0;
            r_carry      <= '0;
            r_res        <= '0;
            r_cc         <= 1'b0;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_out_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sum      <= w_sum_ext;
                        r_carry    <= w_carry_ext;
                        r_cc       <= bus.in_cin;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_res <= w_res_next;
                    r_cc  <= w_csum[CHUNK];
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= ST_DONE;
                        r_out_valid  <= 1'b1;
                        r_out_result <= w_final[WIDTH+1:0];
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.busy       = r_busy;

    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_result));

    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_ready && bus.out_valid));

endmodule
`default_nettype wire

// File: tb/tb_csa_resolve.sv
`default_nettype none
// ============================================================================
// Module  : tb_csa_resolve
// Purpose : Scoreboard bench for csa_resolve with CHUNK=8 (NCH=5) and CHUNK=33.
// Revision: 1.0  initial release
// ============================================================================
module tb_csa_resolve;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    csa_resolve_if #(.WIDTH(W)) b0 ();
    csa_resolve_if #(.WIDTH(W)) b1 ();

    csa_resolve #(.WIDTH(W), .CHUNK(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    csa_resolve #(.WIDTH(W), .CHUNK(33)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int tests_run    = 0;
    int tests_failed = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    logic [W+1:0] q0[$];
    logic [W+1:0] q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] rnd_op();
        logic [W:0] v;
        v[31:0] = $urandom();
        v[32]   = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Present one operand pair, push its reference sum, then scramble inputs.
    task automatic send(input int which, input logic [W:0] s, input logic [W:0] c, input logic ci);
        int n;
        logic [W+1:0] e;
        n = 0;
        e = {1'b0, s} + {1'b0, c} + {{(W+1){1'b0}}, ci};
        @(negedge clk);
        while (!((which == 0) ? b0.in_ready : b1.in_ready)) begin
            if (n >= 100) begin
                tests_run++; tests_failed++;
                $display("FAIL send_timeout dut%0d: in_ready got 0, required 1", which);
                return;
            end
            n++;
            @(negedge clk);
        end
        if (which == 0) begin
            b0.in_valid = 1'b1; b0.in_sum = s; b0.in_carry = c; b0.in_cin = ci;
            q0.push_back(e);
        end else begin
            b1.in_valid = 1'b1; b1.in_sum = s; b1.in_carry = c; b1.in_cin = ci;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (which == 0) begin
            b0.in_valid = 1'b0; b0.in_sum = rnd_op(); b0.in_carry = rnd_op(); b0.in_cin = 1'($urandom_range(0, 1));
        end else begin
            b1.in_valid = 1'b0; b1.in_sum = rnd_op(); b1.in_carry = rnd_op(); b1.in_cin = 1'($urandom_range(0, 1));
        end
    endtask

    // Count edges after acceptance until out_valid is seen (at a negedge).
    task automatic wait_out(input int which, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if ((which == 0) ? b0.out_valid : b1.out_valid) break;
            if (lat >= 200) begin
                tests_run++; tests_failed++;
                $display("FAIL out_valid_timeout dut%0d: out_valid got 0, required 1", which);
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        tests_run++; if (b0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", b0.in_ready); end
        tests_run++; if (b0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", b0.out_valid); end
        tests_run++; if (b0.out_result !== '0) begin tests_failed++; $display("FAIL reset_out_result: got %h, required 0", b0.out_result); end
        tests_run++; if (b0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", b0.busy); end
        tests_run++; if (b1.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready_nch1: got %b, required 1", b1.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic [W+1:0] e;
        send(0, 33'h0_0000_0001, 33'h0_0000_0001, 1'b0);
        wait_out(0, lat);
        e = q0.pop_front();
        tests_run++; if (lat != 5) begin tests_failed++; $display("FAIL basic_latency: got %0d, required 5", lat); end
        tests_run++; if (b0.out_result !== e) begin tests_failed++; $display("FAIL basic_result: got %h, required %h", b0.out_result, e); end
        tests_run++; if (b0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_in_ready_done: got %b, required 0", b0.in_ready); end
        tests_run++; if (b0.busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_done: got %b, required 1", b0.busy); end
        b0.out_ready = 1'b1;
        @(posedge clk); #1 b0.out_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (b0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_out_valid_idle: got %b, required 0", b0.out_valid); end
        tests_run++; if (b0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready_idle: got %b, required 1", b0.in_ready); end
        tests_run++; if (b0.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_idle: got %b, required 0", b0.busy); end
    endtask

    task automatic test_carry_ripple();
        int lat;
        logic [W+1:0] e;
        logic [W:0]   s [2];
        logic [W:0]   c [2];
        s[0] = 33'h1_FFFF_FFFF; c[0] = 33'h1_FFFF_FFFF;
        s[1] = 33'h1_FFFF_FFFF; c[1] = 33'h0_0000_0000;
        for (int i = 0; i < 2; i++) begin
            send(0, s[i], c[i], 1'b1);
            wait_out(0, lat);
            e = q0.pop_front();
            tests_run++; if (b0.out_result !== e) begin tests_failed++; $display("FAIL ripple_result[%0d]: got %h, required %h", i, b0.out_result, e); end
            b0.out_ready = 1'b1;
            @(posedge clk); #1 b0.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W+1:0] e;
        send(0, 33'h0_1234_5678, 33'h1_0000_0001, 1'b1);
        wait_out(0, lat);
        e = q0.pop_front();
        b0.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            tests_run++; if (b0.out_result !== e) begin tests_failed++; $display("FAIL hold_result[%0d]: got %h, required %h", i, b0.out_result, e); end
            tests_run++; if (b0.out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_out_valid[%0d]: got %b, required 1", i, b0.out_valid); end
            tests_run++; if (b0.in_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready[%0d]: got %b, required 0", i, b0.in_ready); end
            tests_run++; if (b0.busy !== 1'b1) begin tests_failed++; $display("FAIL hold_busy[%0d]: got %b, required 1", i, b0.busy); end
        end
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        @(posedge clk); #1 b0.out_ready = 1'b0;
        tests_run++; if (b0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b, required 1", b0.in_ready); end
        tests_run++; if (b0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL release_out_valid: got %b, required 0", b0.out_valid); end
        @(negedge clk);
        tests_run++; if (b0.busy !== 1'b0) begin tests_failed++; $display("FAIL release_busy: got %b, required 0", b0.busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [W+1:0] e;
        send(0, 33'h1_FFFF_0000, 33'h0_0F0F_0F0F, 1'b0);
        void'(q0.pop_front());
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (b0.in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b, required 1", b0.in_ready); end
        tests_run++; if (b0.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b, required 0", b0.out_valid); end
        tests_run++; if (b0.out_result !== '0) begin tests_failed++; $display("FAIL midrst_out_result: got %h, required 0", b0.out_result); end
        tests_run++; if (b0.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b, required 0", b0.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 33'd5, 33'd7, 1'b0);
        wait_out(0, lat);
        e = q0.pop_front();
        tests_run++; if (lat != 5) begin tests_failed++; $display("FAIL midrst_latency: got %0d, required 5", lat); end
        tests_run++; if (b0.out_result !== e) begin tests_failed++; $display("FAIL midrst_result: got %h, required %h", b0.out_result, e); end
        b0.out_ready = 1'b1;
        @(posedge clk); #1 b0.out_ready = 1'b0;
    endtask

    task automatic test_single_chunk();
        int lat;
        logic [W+1:0] e;
        send(1, 33'h1_0000_0000, 33'h1_0000_0000, 1'b0);
        wait_out(1, lat);
        e = q1.pop_front();
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL nch1_latency: got %0d, required 1", lat); end
        tests_run++; if (b1.out_result !== e) begin tests_failed++; $display("FAIL nch1_result: got %h, required %h", b1.out_result, e); end
        b1.out_ready = 1'b1;
        @(posedge clk); #1 b1.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back(input int which);
        int lat;
        int nch;
        int unsigned prev;
        logic [W+1:0] e;
        logic [W+1:0] got;
        nch  = (which == 0) ? 5 : 1;
        prev = 0;
        if (which == 0) b0.out_ready = 1'b1; else b1.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(which, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
            if (i > 0) begin
                tests_run++; if (acc_cyc - prev != nch + 2) begin tests_failed++; $display("FAIL b2b_ii dut%0d[%0d]: got %0d, required %0d", which, i, acc_cyc - prev, nch + 2); end
            end
            prev = acc_cyc;
            wait_out(which, lat);
            e   = (which == 0) ? q0.pop_front() : q1.pop_front();
            got = (which == 0) ? b0.out_result : b1.out_result;
            tests_run++; if (lat != nch) begin tests_failed++; $display("FAIL b2b_latency dut%0d[%0d]: got %0d, required %0d", which, i, lat, nch); end
            tests_run++; if (got !== e) begin tests_failed++; $display("FAIL b2b_result dut%0d[%0d]: got %h, required %h", which, i, got, e); end
        end
        @(posedge clk); #1;
        if (which == 0) b0.out_ready = 1'b0; else b1.out_ready = 1'b0;
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.in_sum = '0; b0.in_carry = '0; b0.in_cin = 1'b0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_sum = '0; b1.in_carry = '0; b1.in_cin = 1'b0; b1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_single_chunk();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
